// File: rtl/brpred_result_monitor.sv
// Branch-predictor test result monitor.
// Watches memory writes to one word address and treats each write there as
// the verdict for one sequential test part: EXPECT_DATA means the part
// passed, anything else counts as an error. A held-high write enable
// (D-cache stall) counts once. The monitor finishes when all parts pass or
// when the optional cycle limit runs out.
module brpred_result_monitor #(
  parameter int          NUM_PARTS   = 3,
  parameter logic [29:0] CHECK_ADDR  = 30'd0,
  parameter logic [31:0] EXPECT_DATA = 32'd0,
  parameter int          ERR_W       = 8,
  parameter int          DUR_W       = 16,
  parameter int          TIMEOUT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [29:0]      addr,
  input  logic [31:0]      data,
  input  logic             wen,
  output logic [ERR_W-1:0] error_num,
  output logic [DUR_W-1:0] duration,
  output logic [3:0]       part_idx,
  output logic             part_done,
  output logic             finish,
  output logic             timed_out,
  output logic             pass
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  localparam logic [3:0]       LAST_PART = 4'(NUM_PARTS - 1);
  // Duration value on the last RUN cycle before the limit expires.
  localparam logic [DUR_W-1:0] TO_LAST   = DUR_W'(TIMEOUT - 1);
  localparam bit               TO_EN     = (TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [3:0]       idx_q, idx_d;
  logic             done_q, done_d;
  logic             armed_q, armed_d;

  logic             ev;
  logic             hit;

  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [DUR_W-1:0] dur_sat_inc(input logic [DUR_W-1:0] v);
    return (v == {DUR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // One event per rising wen: armed only after a cycle with wen low.
  assign ev  = wen & armed_q;
  assign hit = ev && (addr == CHECK_ADDR) && (state_q == ST_RUN);

  // Next-state decode for the state machine and its counters.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    dur_d   = dur_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    armed_d = ~wen;
    if (state_q == ST_RUN) begin
      dur_d = dur_sat_inc(dur_q);
      if (TO_EN && (dur_q == TO_LAST)) begin
        state_d = ST_TIMEOUT;
      end
      if (hit) begin
        if (data == EXPECT_DATA) begin
          done_d = 1'b1;
          if (idx_q == LAST_PART) begin
            // Finishing the last part outranks a simultaneous timeout.
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          err_d = err_sat_inc(err_q);
        end
      end
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      err_q   <= '0;
      dur_q   <= '0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      dur_q   <= dur_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end

  assign error_num = err_q;
  assign duration  = dur_q;
  assign part_idx  = idx_q;
  assign part_done = done_q;
  assign finish    = (state_q != ST_RUN);
  assign timed_out = (state_q == ST_TIMEOUT);
  assign pass      = finish & ~timed_out & (err_q == '0);

endmodule

// File: tb/tb_brpred_result_monitor.sv
// Bench for brpred_result_monitor: three instances (defaults, ERR_W=2,
// TIMEOUT=20), each with its own write enable. Expected part_done pulses go
// into a queue; a negedge monitor pops and compares them.
module tb_brpred_result_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] data = '0;
  logic [2:0]  wen = '0;

  logic [7:0]  err0, err2;
  logic [1:0]  err1;
  logic [15:0] dur [3];
  logic [3:0]  pidx [3];
  logic        pdone [3];
  logic        fin [3];
  logic        tmo [3];
  logic        pas [3];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0] inst;
    logic [3:0] idx;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_pop;

  always #5 clk = ~clk;

  brpred_result_monitor u_dflt (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen[0]),
    .error_num(err0), .duration(dur[0]), .part_idx(pidx[0]),
    .part_done(pdone[0]), .finish(fin[0]), .timed_out(tmo[0]), .pass(pas[0])
  );

  brpred_result_monitor #(.ERR_W(2)) u_err (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen[1]),
    .error_num(err1), .duration(dur[1]), .part_idx(pidx[1]),
    .part_done(pdone[1]), .finish(fin[1]), .timed_out(tmo[1]), .pass(pas[1])
  );

  brpred_result_monitor #(.TIMEOUT(20)) u_to (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen[2]),
    .error_num(err2), .duration(dur[2]), .part_idx(pidx[2]),
    .part_done(pdone[2]), .finish(fin[2]), .timed_out(tmo[2]), .pass(pas[2])
  );

  // Scoreboard monitor: every part_done pulse must match the queue head.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pdone[k] === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL part_done_unexpected: inst %0d idx %0d, required no pulse", k, pidx[k]);
        end else begin
          e_pop = exp_q.pop_front();
          if ((32'(e_pop.inst) != k) || (pidx[k] !== e_pop.idx)) begin
            n_errors++;
            $display("FAIL part_done_match: inst %0d idx %0d, required inst %0d idx %0d",
                     k, pidx[k], e_pop.inst, e_pop.idx);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] get_err(input int k);
    case (k)
      0:       return 32'(err0);
      1:       return 32'(err1);
      default: return 32'(err2);
    endcase
  endfunction

  task automatic check_status(input string tag, input int k, input logic [31:0] e_err,
                              input logic [31:0] e_idx, input logic e_fin,
                              input logic e_tmo, input logic e_pas);
    chk({tag, "_error_num"}, get_err(k), e_err);
    chk({tag, "_part_idx"}, 32'(pidx[k]), e_idx);
    chk({tag, "_finish"}, 32'(fin[k]), 32'(e_fin));
    chk({tag, "_timed_out"}, 32'(tmo[k]), 32'(e_tmo));
    chk({tag, "_pass"}, 32'(pas[k]), 32'(e_pas));
  endtask

  // Applies one reset edge (wen optionally held high) and checks the cleared state.
  task automatic do_reset(input int k, input logic hold_wen);
    rst = 1'b1;
    wen = '0;
    wen[k] = hold_wen;
    step();
    rst = 1'b0;
    check_status("reset", k, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("reset_duration", 32'(dur[k]), 0);
    chk("reset_part_done", 32'(pdone[k]), 0);
  endtask

  task automatic write1(input int k, input logic [29:0] a, input logic [31:0] d);
    addr = a;
    data = d;
    wen[k] = 1'b1;
    step();
    wen[k] = 1'b0;
    step();
  endtask

  task automatic expect_pulse(input int k, input int idx);
    exp_t e;
    e.inst = 2'(k);
    e.idx  = 4'(idx);
    exp_q.push_back(e);
  endtask

  initial begin
    // Three passing writes complete all parts.
    do_reset(0, 1'b0);
    step();
    expect_pulse(0, 1); write1(0, 30'd0, 32'd0);
    chk("basic_idx1", 32'(pidx[0]), 1);
    expect_pulse(0, 2); write1(0, 30'd0, 32'd0);
    chk("basic_idx2", 32'(pidx[0]), 2);
    check_status("basic_mid", 0, 0, 2, 1'b0, 1'b0, 1'b0);
    expect_pulse(0, 2); write1(0, 30'd0, 32'd0);
    check_status("basic_end", 0, 0, 2, 1'b1, 1'b0, 1'b1);

    // Held-high wen produces one event.
    do_reset(0, 1'b0);
    step();
    expect_pulse(0, 1);
    addr = 30'd0; data = 32'd0; wen[0] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    wen[0] = 1'b0;
    step();
    check_status("hold", 0, 0, 1, 1'b0, 1'b0, 1'b0);

    // One failing write, ignored address, then three passes.
    do_reset(0, 1'b0);
    step();
    write1(0, 30'd0, 32'd5);
    check_status("fail1", 0, 1, 0, 1'b0, 1'b0, 1'b0);
    write1(0, 30'd4, 32'd7);
    check_status("other_addr_run", 0, 1, 0, 1'b0, 1'b0, 1'b0);
    expect_pulse(0, 1); write1(0, 30'd0, 32'd0);
    expect_pulse(0, 2); write1(0, 30'd0, 32'd0);
    expect_pulse(0, 2); write1(0, 30'd0, 32'd0);
    check_status("fail_end", 0, 1, 2, 1'b1, 1'b0, 1'b0);
    write1(0, 30'd4, 32'd7);
    write1(0, 30'd0, 32'd9);
    check_status("after_done", 0, 1, 2, 1'b1, 1'b0, 1'b0);

    // Error counter saturation with ERR_W=2.
    do_reset(1, 1'b0);
    step();
    write1(1, 30'd0, 32'd1);
    write1(1, 30'd0, 32'd1);
    chk("sat_err2", get_err(1), 2);
    write1(1, 30'd0, 32'd1);
    chk("sat_err3", get_err(1), 3);
    write1(1, 30'd0, 32'd1);
    write1(1, 30'd0, 32'd1);
    check_status("sat_end", 1, 3, 0, 1'b0, 1'b0, 1'b0);

    // Timeout after 20 RUN cycles with no writes.
    do_reset(2, 1'b0);
    for (int i = 0; i < 19; i++) step();
    chk("to_dur19", 32'(dur[2]), 19);
    chk("to_fin_early", 32'(fin[2]), 0);
    step();
    check_status("to_hit", 2, 0, 0, 1'b1, 1'b1, 1'b0);
    chk("to_dur20", 32'(dur[2]), 20);
    step(); step();
    chk("to_dur_frozen", 32'(dur[2]), 20);

    // Final passing write on the timeout edge: DONE wins.
    do_reset(2, 1'b0);
    step();
    addr = 30'd0; data = 32'd0;
    expect_pulse(2, 1);
    wen[2] = 1'b1; step();
    wen[2] = 1'b0; step();
    expect_pulse(2, 2);
    wen[2] = 1'b1; step();
    wen[2] = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("race_dur19", 32'(dur[2]), 19);
    expect_pulse(2, 2);
    wen[2] = 1'b1; step();
    wen[2] = 1'b0;
    check_status("race", 2, 0, 2, 1'b1, 1'b0, 1'b1);
    chk("race_dur20", 32'(dur[2]), 20);
    step();

    // Reset while wen is high after a passing part.
    do_reset(0, 1'b0);
    step();
    addr = 30'd0; data = 32'd0;
    expect_pulse(0, 1);
    wen[0] = 1'b1; step();
    chk("rst_mid_idx1", 32'(pidx[0]), 1);
    do_reset(0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    check_status("rst_hold", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    wen[0] = 1'b0; step();
    expect_pulse(0, 1);
    wen[0] = 1'b1; step();
    wen[0] = 1'b0; step();
    chk("rst_rearm_idx", 32'(pidx[0]), 1);

    step(); step();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/brpred_result_monitor.md
BRPRED_RESULT_MONITOR -- requirements
Module: brpred_result_monitor

Interface
REQ-001 Parameter NUM_PARTS, default 3, number of sequential test parts to pass (1..16).
REQ-002 Parameter CHECK_ADDR, default 30'd0, word address monitored for result writes.
REQ-003 Parameter EXPECT_DATA, default 32'd0, data value meaning "part passed".
REQ-004 Parameter ERR_W, default 8, width of error counter.
REQ-005 Parameter DUR_W, default 16, width of cycle counter.
REQ-006 Parameter TIMEOUT, default 0, cycle limit; 0 disables timeout.
REQ-007 clk  input  1  sole clock, all state updates on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 addr  input  30  word address of the observed memory write.
REQ-010 data  input  32  write data of the observed memory write.
REQ-011 wen  input  1  write enable; may stay high several cycles during a D-cache stall.
REQ-012 error_num  output  ERR_W  count of failing result writes.
REQ-013 duration  output  DUR_W  cycles spent in RUN.
REQ-014 part_idx  output  4  index of the part currently being checked.
REQ-015 part_done  output  1  one-cycle pulse when a part passes.
REQ-016 finish  output  1  high when monitor left RUN (DONE or TIMEOUT).
REQ-017 timed_out  output  1  high in TIMEOUT state.
REQ-018 pass  output  1  finish & ~timed_out & (error_num==0).

Function
REQ-019 State machine SHALL have states RUN, DONE, TIMEOUT; DONE and TIMEOUT are terminal until rst.
REQ-020 An "armed" flag SHALL gate events: event accepted iff wen=1 and armed=1; armed clears on any cycle with wen=1, sets on any cycle with wen=0.
REQ-021 A held-high wen SHALL produce exactly one event; a new event requires at least one wen=0 cycle.
REQ-022 Events with addr != CHECK_ADDR SHALL be ignored (still disarm).
REQ-023 Accepted event at CHECK_ADDR in RUN with data==EXPECT_DATA: part_done pulses next cycle; part_idx increments; if part_idx was NUM_PARTS-1, next state DONE and part_idx holds at NUM_PARTS-1.
REQ-024 Accepted event at CHECK_ADDR in RUN with data!=EXPECT_DATA: error_num increments, saturating at 2^ERR_W-1; part_idx unchanged.
REQ-025 Events in DONE or TIMEOUT SHALL change no counter or output.
REQ-026 duration SHALL increment every cycle in RUN, saturating at 2^DUR_W-1, and freeze in DONE/TIMEOUT.
REQ-027 With TIMEOUT!=0, RUN with duration==TIMEOUT-1 SHALL move to TIMEOUT next cycle (duration reads TIMEOUT after transition).
REQ-028 Same-cycle final passing event and timeout condition: DONE wins, timed_out stays 0.
REQ-029 finish, timed_out SHALL be decoded from the registered state (assert the cycle after the transitioning edge); pass combinational from registered values.
REQ-030 Simulation-only $display per part completion and final PASS/FAIL banner permitted; excluded from synthesis.

Reset
REQ-031 rst=1 at a rising edge SHALL force: state RUN, error_num 0, duration 0, part_idx 0, part_done 0, armed 0, finish 0, timed_out 0, pass 0.
REQ-032 rst mid-operation (any state) SHALL apply REQ-031 on that edge; wen high during/after reset produces no event until wen has been low one cycle.

Verification
REQ-033 Defaults; three single-cycle writes addr=0,data=0 separated by idle -> part_done x3, part_idx 0->1->2, finish=1, pass=1, error_num=0.
REQ-034 wen held high 5 cycles with addr=0,data=0 -> exactly one part_done, part_idx=1.
REQ-035 Writes addr=0 data=5, then data=0 x3 -> error_num=1, finish=1, pass=0; write addr=4,data=7 -> no effect.
REQ-036 ERR_W=2, five failing writes -> error_num saturates at 3.
REQ-037 TIMEOUT=20, no writes -> finish and timed_out assert after 20 RUN cycles, duration=20, pass=0; final pass write on the timeout cycle -> DONE, timed_out=0.
REQ-038 rst pulsed after one passing part while wen high -> all outputs 0, no event until wen drops and rises.
